// File: rtl/csr_pkg.sv
// Shared definitions for the CSR write path: region map, default widths
// and the occupancy-width helper used by the posted-write FIFO.
// No logic, no latency, no backpressure.
package csr_pkg;

    // Region indices (high address bits) of the blocks hanging off the bus.
    localparam int REG_PWR = 0;
    localparam int REG_RX1 = 1;
    localparam int REG_RX2 = 2;
    localparam int REG_TX1 = 3;
    localparam int REG_TX2 = 4;
    localparam int REG_MEM = 5;

    // Default bus geometry.
    localparam int CSR_DW = 8;
    localparam int CSR_OW = 3;
    localparam int CSR_RW = 3;

    // Bits needed to hold an entry count of 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/csr_post_fifo.sv
// Synchronous in-order FIFO for posted CSR memory writes.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is refused when full unless a pop happens the same cycle.
//
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_push, i_din       write request and entry
//   i_pop               read request (ignored while empty)
//   o_dout              head entry; holds the last popped head while empty
//   o_full, o_empty     status
//   o_count             current entry count (registered)
module csr_post_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_last;

    logic             w_full;
    logic             w_empty;
    logic             w_do_pop;
    logic             w_do_push;
    logic [IW-1:0]    w_wr_idx;
    logic [IW-1:0]    w_rd_idx;

    assign w_wr_idx = r_wr_ptr[IW-1:0];
    assign w_rd_idx = r_rd_ptr[IW-1:0];

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[IW] != r_rd_ptr[IW]) && (w_wr_idx == w_rd_idx);

    assign w_do_pop  = i_pop && !w_empty;
    // When full, the slot being popped this cycle is the one the push lands in;
    // the read is combinational so the outgoing value is already taken.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[w_wr_idx] <= i_din;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_last   <= r_mem[w_rd_idx];
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // While empty the slot at the read pointer is stale; present the last
    // value that actually left the head instead.
    assign o_dout  = w_empty ? r_last : r_mem[w_rd_idx];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/csr_wr_post_ctrl.sv
// CSR write decoder with an in-order posted-write queue for the memory region.
// Latency: strobe/data/offset 1 cycle after the bus write; memory head 2 cycles.
// Backpressure: memory side is valid/ready; writes are held while not ready,
// a push into a full queue with no pop is dropped and flags sticky overflow.
//
// Ports:
//   i_clk, i_reset                    clock, asynchronous active-high reset
//   i_reg_wr, i_reg_addr, i_reg_datain host write; addr = {region, offset}
//   o_reg_wr_strb                     one-hot per-region write pulse
//   o_reg_wr_data, o_reg_wr_offs      registered data/offset of last decoded write
//   o_mem_wr_valid, i_mem_wr_ready    memory write handshake
//   o_mem_wr_addr, o_mem_wr_data      queue head
//   o_mem_pending                     queue occupancy
//   o_mem_ovf, i_mem_ovf_clr          sticky overflow flag and its clear
module csr_wr_post_ctrl
    import csr_pkg::*;
#(
    parameter int DW         = CSR_DW,
    parameter int OW         = CSR_OW,
    parameter int RW         = CSR_RW,
    parameter int NREG       = 6,
    parameter int MEM_REGION = REG_MEM,
    parameter int DEPTH      = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_reg_wr,
    input  logic [RW+OW-1:0]             i_reg_addr,
    input  logic [DW-1:0]                i_reg_datain,
    output logic [NREG-1:0]              o_reg_wr_strb,
    output logic [DW-1:0]                o_reg_wr_data,
    output logic [OW-1:0]                o_reg_wr_offs,
    output logic                         o_mem_wr_valid,
    input  logic                         i_mem_wr_ready,
    output logic [OW-1:0]                o_mem_wr_addr,
    output logic [DW-1:0]                o_mem_wr_data,
    output logic [occ_width(DEPTH)-1:0]  o_mem_pending,
    output logic                         o_mem_ovf,
    input  logic                         i_mem_ovf_clr
);

    localparam int AW = RW + OW;
    localparam int EW = OW + DW;

    // ------------------------------------------------------------------
    // Decode stage
    // ------------------------------------------------------------------
    logic [RW-1:0]   w_region;
    logic [OW-1:0]   w_offs;
    logic            w_hit;
    logic [NREG-1:0] w_strb_nxt;

    logic [NREG-1:0] r_strb;
    logic [DW-1:0]   r_data;
    logic [OW-1:0]   r_offs;

    assign w_region = i_reg_addr[AW-1:OW];
    assign w_offs   = i_reg_addr[OW-1:0];

    // Region codes at or above NREG are unimplemented and decode to nothing.
    assign w_hit = i_reg_wr && (int'(w_region) < NREG);

    always_comb begin
        w_strb_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            if (w_hit && (int'(w_region) == i)) begin
                w_strb_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_strb <= '0;
            r_data <= '0;
            r_offs <= '0;
        end else begin
            r_strb <= w_strb_nxt;
            // Data/offset only move on a decoded write so the blocks see a
            // stable value between strobes.
            if (w_hit) begin
                r_data <= i_reg_datain;
                r_offs <= w_offs;
            end
        end
    end

    assign o_reg_wr_strb = r_strb;
    assign o_reg_wr_data = r_data;
    assign o_reg_wr_offs = r_offs;

    // ------------------------------------------------------------------
    // Posted-write queue for the memory region
    // ------------------------------------------------------------------
    logic                        w_push;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic [EW-1:0]               w_head;
    logic [occ_width(DEPTH)-1:0] w_count;
    logic                        w_drop;
    logic                        r_ovf;

    // Push comes from the registered strobe, so the queue never sees the raw
    // bus and the head is at the earliest two cycles after the bus write.
    assign w_push = r_strb[MEM_REGION];
    assign w_pop  = !w_empty && i_mem_wr_ready;

    csr_post_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_din   ({r_offs, r_data}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_drop = w_push && w_full && !w_pop;

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (i_mem_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign o_mem_wr_valid = !w_empty;
    assign o_mem_wr_addr  = w_head[EW-1:DW];
    assign o_mem_wr_data  = w_head[DW-1:0];
    assign o_mem_pending  = w_count;
    assign o_mem_ovf      = r_ovf;

endmodule

// File: doc/csr_wr_post_ctrl.md
Name: csr_wr_post_ctrl

Overview:
- Parametrised successor of the CSR write decoder.
- Decodes register-bus writes into per-region one-cycle write strobes with registered data and offset.
- Writes to the memory region go into an in-order posted-write FIFO. The FIFO drains to the CSR memory through a valid/ready handshake, so writes issued while memory is unpowered or busy are kept, not lost.
- Sits between the host register bus and the PWR/RX/TX register blocks and the CSR memory.

Parameters:
- DW, 8, data width.
- OW, 3, offset bits within a region (low address bits).
- RW, 3, region-select bits (high address bits); address width AW = RW+OW.
- NREG, 6, number of implemented regions; must be <= 2**RW.
- MEM_REGION, 5, region index routed to the posted-write FIFO; must be < NREG.
- DEPTH, 4, FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- reg_wr  in  1  host write strobe
- reg_addr  in  AW  host address; [AW-1:OW] = region, [OW-1:0] = offset
- reg_datain  in  DW  host write data
- reg_wr_strb  out  NREG  one-hot per-region write pulse
- reg_wr_data  out  DW  registered write data
- reg_wr_offs  out  OW  registered offset
- mem_wr_valid  out  1  FIFO head valid
- mem_wr_ready  in  1  memory accepts (low while powered down)
- mem_wr_addr  out  OW  head offset
- mem_wr_data  out  DW  head data
- mem_pending  out  $clog2(DEPTH+1)  FIFO occupancy
- mem_ovf  out  1  sticky overflow flag
- mem_ovf_clr  in  1  clears mem_ovf

Behaviour:
- Reset (asynchronous, active-high): reg_wr_strb=0, reg_wr_data=0, reg_wr_offs=0, FIFO empty, mem_wr_valid=0, mem_pending=0, mem_ovf=0.
  - Reset asserted mid-operation discards all pending writes. Nothing reaches memory after reset.
- Decode stage, latency 1:
  - Cycle N with reg_wr=1 and region r<NREG -> cycle N+1: reg_wr_strb[r]=1 for exactly one cycle, reg_wr_data=reg_datain(N), reg_wr_offs=offset(N).
  - reg_wr=0 or r>=NREG -> reg_wr_strb=0 the next cycle; data/offset hold their previous value.
  - Back-to-back writes give back-to-back strobes.
  - reg_wr_strb[MEM_REGION] also pulses, for notification only.
- Push: in cycle N+1 a decoded MEM_REGION write pushes {offs,data} into the FIFO.
  - Earliest mem_wr_valid is cycle N+2; there is no combinational bypass.
- Pop: a transfer occurs when mem_wr_valid && mem_wr_ready.
  - Head advances the next cycle; at most one pop per cycle.
  - Drain order is strictly FIFO.
  - mem_wr_addr/data are stable while valid && !ready.
- Occupancy:
  - Push only: +1. Pop only: -1. Push and pop together: unchanged.
  - mem_pending is registered and equals the entry count.
- Full:
  - Push while full with a pop in the same cycle: accepted.
  - Push while full with no pop: the write is dropped, the FIFO is unchanged, and mem_ovf is set the next cycle.
- mem_ovf:
  - Stays set until mem_ovf_clr=1, which clears it the next cycle.
  - Set and clear in the same cycle: set wins.
- Empty: mem_wr_valid=0. mem_wr_addr/data are don't-care but must not be X after reset; drive the last head value.
- Pointers: log2(DEPTH)+1 bits, wrapping naturally. Full = MSBs differ and LSBs are equal.
- mem_wr_ready held low for any duration: entries are retained; draining resumes one entry per cycle once ready returns.
- No region other than MEM_REGION is buffered. Its strobes are independent of FIFO state.

Decomposition:
- Shared package csr_pkg holds:
  - region index constants REG_PWR=0, REG_RX1=1, REG_RX2=2, REG_TX1=3, REG_TX2=4, REG_MEM=5;
  - the default DW/OW/RW;
  - a function for occupancy width.
- One sub-module: csr_post_fifo, a synchronous FIFO with DEPTH/WIDTH parameters, push/pop, full/empty, count, and asynchronous active-high reset.
- Decode logic and ovf flag stay in the top module.

Test Plan:
- Decode: write addr=6'b010_011, data=8'hA5 -> one cycle later reg_wr_strb=6'b000100, reg_wr_offs=3, reg_wr_data=8'hA5; one cycle later strobe=0. Addr region 7 -> no strobe.
- Passthrough: mem_wr_ready=1, write 6'b101_010 data 8'h3C in cycle 0 -> cycle 2 mem_wr_valid=1, addr=2, data=8'h3C; cycle 3 valid=0, mem_pending=0.
- Power-down hold:
  - With ready=0, write offsets 0,1,2,3 with data 8'h10..8'h13 -> mem_pending=4, mem_ovf=0.
  - Raise ready -> four consecutive transfers in order 0/10, 1/11, 2/12, 3/13, then valid=0.
- Overflow: ready=0 with FIFO full (4 entries), write offset 5 data 8'hFF -> mem_ovf=1, mem_pending=4, entry dropped (never emitted); pulse mem_ovf_clr -> mem_ovf=0 next cycle.
- Full with simultaneous pop: FIFO full, ready=1, and a new push lands in the pop cycle -> accepted, mem_pending stays 4, mem_ovf=0, new entry emitted fifth.
- Reset mid-drain: 3 entries pending with ready toggling; assert reset asynchronously mid-cycle -> outputs zero immediately, mem_pending=0, no further mem_wr_valid after release until a new write.
